wb_bram_arbiter: RTL and testbench

- Shares one single-port user BRAM (1-cycle read latency) between two requesters: the Wishbone slave path routed by WB_decoder, and the FIR engine's tap/data port.
- Round-robin arbitration with a programmable wait-state count before each access, matching the exmem delay model.
- Sits between WB_decoder and the BRAM macro inside user_project_wrapper.

---
 rtl/wb_bram_pkg.sv | 10 +
 rtl/wb_bram_rr_arb.sv | 25 ++
 rtl/wb_bram_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_bram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// rtl/wb_bram_pkg.sv - shared types and default sizes for the WB/engine BRAM arbiter
package wb_bram_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DELAYS = 10;

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, ACK} state_t;
    typedef enum logic {OWN_WB, OWN_ENG} owner_t;

endpackage

// File: rtl/wb_bram_rr_arb.sv
// rtl/wb_bram_rr_arb.sv - two-way round-robin arbiter, one-hot grant {eng, wb}
module wb_bram_rr_arb
    import wb_bram_pkg::*;
(
    input  logic       req_wb,
    input  logic       req_eng,
    input  owner_t     last_owner,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req_wb && req_eng) begin
                gnt = (last_owner == OWN_ENG) ? 2'b01 : 2'b10;
            end else if (req_wb) begin
                gnt = 2'b01;
            end else if (req_eng) begin
                gnt = 2'b10;
            end
        end
    end

endmodule

// File: rtl/wb_bram_arbiter.sv
// rtl/wb_bram_arbiter.sv - shares one single-port BRAM between Wishbone and the FIR engine
module wb_bram_arbiter
    import wb_bram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 32,
    parameter int DELAYS = DEF_DELAYS
) (
    input  logic              wbs_clk_i,
    input  logic              wbs_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    input  logic              eng_req_i,
    input  logic              eng_we_i,
    input  logic [ADDR_W-1:0] eng_adr_i,
    input  logic [DATA_W-1:0] eng_dat_i,
    output logic              eng_gnt_o,
    output logic              eng_ack_o,
    output logic [DATA_W-1:0] eng_dat_o,
    output logic              bram_en_o,
    output logic [3:0]        bram_we_o,
    output logic [ADDR_W-1:0] bram_adr_o,
    output logic [DATA_W-1:0] bram_wdat_o,
    input  logic [DATA_W-1:0] bram_rdat_i
);

    localparam int CNT_W = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DELAYS > 0) ? DELAYS - 1 : 0);

    state_t              state, state_nxt;
    owner_t              owner, last_owner;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [3:0]          lat_sel;
    logic [ADDR_W-1:0]   lat_adr;
    logic [DATA_W-1:0]   lat_wdat;
    logic [DATA_W-1:0]   rdata;
    logic                wb_abort;
    logic [1:0]          gnt;
    logic                wb_req;
    logic                wb_dropped;
    logic                unused_adr;

    assign wb_req     = wbs_cyc_i & wbs_stb_i;
    assign wb_dropped = (owner == OWN_WB) && !wbs_cyc_i;
    // WB_decoder has already selected this target, so only the word index matters
    assign unused_adr = &{1'b0, wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    wb_bram_rr_arb u_arb (
        .req_wb     (wb_req),
        .req_eng    (eng_req_i),
        .last_owner (last_owner),
        .en         (state == IDLE),
        .gnt        (gnt)
    );

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
        if (wbs_rst_i) begin
            owner      <= OWN_WB;
            last_owner <= OWN_ENG;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_sel    <= 4'h0;
            lat_adr    <= '0;
            lat_wdat   <= '0;
            rdata      <= '0;
            wb_abort   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        owner    <= gnt[1] ? OWN_ENG : OWN_WB;
                        lat_we   <= gnt[1] ? eng_we_i : wbs_we_i;
                        lat_sel  <= gnt[1] ? 4'hF : wbs_sel_i;
                        lat_adr  <= gnt[1] ? eng_adr_i : wbs_adr_i[ADDR_W+1:2];
                        lat_wdat <= gnt[1] ? eng_dat_i : wbs_dat_i;
                        cnt      <= '0;
                        wb_abort <= 1'b0;
                    end
                end
                WAIT:    cnt <= cnt + CNT_W'(1);
                // a late abort still finishes the BRAM cycle but must not ack
                ACCESS:  if (wb_dropped) wb_abort <= 1'b1;
                CAPTURE: begin
                    rdata <= bram_rdat_i;
                    if (wb_dropped) wb_abort <= 1'b1;
                end
                ACK:     last_owner <= owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        bram_en_o   = 1'b0;
        bram_we_o   = 4'h0;
        bram_adr_o  = '0;
        bram_wdat_o = '0;
        wbs_ack_o   = 1'b0;
        wbs_dat_o   = '0;
        eng_ack_o   = 1'b0;
        eng_dat_o   = '0;
        eng_gnt_o   = (state != IDLE) && (owner == OWN_ENG);
        case (state)
            IDLE: begin
                if (gnt != 2'b00) state_nxt = (DELAYS == 0) ? ACCESS : WAIT;
            end
            WAIT: begin
                if (wb_dropped) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt   = CAPTURE;
                bram_en_o   = 1'b1;
                bram_adr_o  = lat_adr;
                bram_wdat_o = lat_wdat;
                if (lat_we) bram_we_o = (owner == OWN_WB) ? lat_sel : 4'hF;
            end
            CAPTURE: state_nxt = ACK;
            ACK: begin
                state_nxt = IDLE;
                if (owner == OWN_ENG) begin
                    eng_ack_o = 1'b1;
                    eng_dat_o = rdata;
                end else if (!wb_abort) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb/tb_wb_bram_arbiter.sv - scoreboard bench for wb_bram_arbiter (DELAYS=10 and DELAYS=0)
`timescale 1ns/1ps
module tb_wb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic        eng_req_i, eng_we_i, eng_gnt_o, eng_ack_o;
    logic [11:0] eng_adr_i;
    logic [31:0] eng_dat_i, eng_dat_o;
    logic        bram_en_o;
    logic [3:0]  bram_we_o;
    logic [11:0] bram_adr_o;
    logic [31:0] bram_wdat_o, bram_rdat;

    logic        z_wbs_ack;
    logic [31:0] z_wbs_dat;
    logic        z_eng_req, z_eng_we, z_eng_gnt, z_eng_ack;
    logic [11:0] z_eng_adr;
    logic [31:0] z_eng_dat, z_eng_rd;
    logic        z_bram_en;
    logic [3:0]  z_bram_we;
    logic [11:0] z_bram_adr;
    logic [31:0] z_bram_wdat, z_bram_rdat;

    wb_bram_arbiter #(.ADDR_W(12), .DATA_W(32), .DELAYS(10)) dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_adr_i(eng_adr_i),
        .eng_dat_i(eng_dat_i), .eng_gnt_o(eng_gnt_o), .eng_ack_o(eng_ack_o),
        .eng_dat_o(eng_dat_o),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_adr_o(bram_adr_o),
        .bram_wdat_o(bram_wdat_o), .bram_rdat_i(bram_rdat)
    );

    wb_bram_arbiter #(.ADDR_W(12), .DATA_W(32), .DELAYS(0)) z_dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst),
        .wbs_cyc_i(1'b0), .wbs_stb_i(1'b0), .wbs_we_i(1'b0),
        .wbs_sel_i(4'h0), .wbs_adr_i(32'h0), .wbs_dat_i(32'h0),
        .wbs_ack_o(z_wbs_ack), .wbs_dat_o(z_wbs_dat),
        .eng_req_i(z_eng_req), .eng_we_i(z_eng_we), .eng_adr_i(z_eng_adr),
        .eng_dat_i(z_eng_dat), .eng_gnt_o(z_eng_gnt), .eng_ack_o(z_eng_ack),
        .eng_dat_o(z_eng_rd),
        .bram_en_o(z_bram_en), .bram_we_o(z_bram_we), .bram_adr_o(z_bram_adr),
        .bram_wdat_o(z_bram_wdat), .bram_rdat_i(z_bram_rdat)
    );

    logic outs_any, z_outs_any;
    assign outs_any = |{wbs_ack_o, wbs_dat_o, eng_gnt_o, eng_ack_o, eng_dat_o,
                        bram_en_o, bram_we_o, bram_adr_o, bram_wdat_o};
    assign z_outs_any = |{z_wbs_ack, z_wbs_dat, z_eng_gnt, z_eng_ack, z_eng_rd,
                          z_bram_en, z_bram_we, z_bram_adr, z_bram_wdat};

    logic        mem_clr;
    logic [31:0] mem   [0:4095];
    logic [31:0] z_mem [0:4095];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i]   <= 32'h0;
                z_mem[i] <= 32'h0;
            end
        end else begin
            if (bram_en_o) begin
                for (int b = 0; b < 4; b++)
                    if (bram_we_o[b]) mem[bram_adr_o][8*b +: 8] <= bram_wdat_o[8*b +: 8];
                bram_rdat <= mem[bram_adr_o];
            end
            if (z_bram_en) begin
                for (int b = 0; b < 4; b++)
                    if (z_bram_we[b]) z_mem[z_bram_adr][8*b +: 8] <= z_bram_wdat[8*b +: 8];
                z_bram_rdat <= z_mem[z_bram_adr];
            end
        end
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct packed {
        logic        eng;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t0 = 0;
    int   en_n, en_at, wb_ack_n, wb_ack_at, eng_ack_n, eng_ack_at, gnt_n, gnt_first;
    logic [11:0] en_adr;
    logic [3:0]  en_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input logic eng, input logic [31:0] dat);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_ack", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_owner", 32'(eng), 32'(e.eng));
            if (e.rd) check("sb_rdata", dat, e.data);
        end
    endtask

    task automatic start();
        @(posedge clk); #1;
        t0 = cyc_n;
    endtask

    task automatic wb_issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] exp_rd);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        sb_q.push_back('{eng: 1'b0, rd: !we, data: exp_rd});
    endtask

    task automatic eng_issue(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                             input logic [31:0] exp_rd);
        eng_req_i = 1'b1; eng_we_i = we; eng_adr_i = adr; eng_dat_i = dat;
        sb_q.push_back('{eng: 1'b1, rd: !we, data: exp_rd});
    endtask

    // one iteration per cycle: sample at negedge, release acked requesters after the next posedge
    task automatic observe(input int ncyc, input int abort_at);
        int   off;
        logic drop_wb, drop_eng;
        en_n = 0; en_at = -1; wb_ack_n = 0; wb_ack_at = -1;
        eng_ack_n = 0; eng_ack_at = -1; gnt_n = 0; gnt_first = -1;
        en_adr = '0; en_we = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            off = cyc_n - t0;
            drop_wb = 1'b0; drop_eng = 1'b0;
            if (bram_en_o) begin
                en_n++; en_at = off; en_adr = bram_adr_o; en_we = bram_we_o;
            end else begin
                check("bram_idle_zero", 32'(|{bram_we_o, bram_adr_o, bram_wdat_o}), 32'd0);
            end
            if (eng_gnt_o) begin
                gnt_n++;
                if (gnt_first < 0) gnt_first = off;
            end
            if (wbs_ack_o) begin
                wb_ack_n++; wb_ack_at = off; drop_wb = 1'b1;
                sb_pop(1'b0, wbs_dat_o);
            end else begin
                check("wb_dat_zero", wbs_dat_o, 32'd0);
            end
            if (eng_ack_o) begin
                eng_ack_n++; eng_ack_at = off; drop_eng = 1'b1;
                sb_pop(1'b1, eng_dat_o);
            end else begin
                check("eng_dat_zero", eng_dat_o, 32'd0);
            end
            @(posedge clk); #1;
            if (drop_wb || (off + 1 == abort_at)) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            if (drop_eng) eng_req_i = 1'b0;
        end
    endtask

    task automatic z_run(input logic we, input logic [11:0] adr, input logic [31:0] dat,
                         output int z_en_at, output int z_ack_at, output int z_gnt_n,
                         output logic [31:0] z_rd);
        start();
        z_eng_req = 1'b1; z_eng_we = we; z_eng_adr = adr; z_eng_dat = dat;
        z_en_at = -1; z_ack_at = -1; z_gnt_n = 0; z_rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (z_bram_en) z_en_at = cyc_n - t0;
            if (z_eng_gnt) z_gnt_n++;
            if (z_eng_ack) begin
                z_ack_at = cyc_n - t0;
                z_rd = z_eng_rd;
            end
            @(posedge clk); #1;
            if (z_ack_at >= 0) z_eng_req = 1'b0;
        end
        z_eng_req = 1'b0;
    endtask

    int          z_en_at, z_ack_at, z_gnt_n;
    logic [31:0] z_rd;

    initial begin
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        eng_req_i = 0; eng_we_i = 0; eng_adr_i = 0; eng_dat_i = 0;
        z_eng_req = 0; z_eng_we = 0; z_eng_adr = 0; z_eng_dat = 0;
        mem_clr = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'(outs_any), 32'd0);
        check("z_rst_outs", 32'(z_outs_any), 32'd0);
        mem_clr = 1'b0;
        rst = 1'b0;

        // WB write to word 4
        start();
        wb_issue(1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 32'h0);
        observe(16, -1);
        check("wr_en_n",   32'(en_n), 32'd1);
        check("wr_en_at",  32'(en_at), 32'd11);
        check("wr_en_adr", 32'(en_adr), 32'd4);
        check("wr_en_we",  32'(en_we), 32'hF);
        check("wr_ack_at", 32'(wb_ack_at), 32'd13);
        check("wr_ack_n",  32'(wb_ack_n), 32'd1);
        check("wr_mem4",   mem[4], 32'hDEAD_BEEF);

        // WB read of word 4
        start();
        wb_issue(1'b0, 32'h3800_0010, 4'hF, 32'h0, 32'hDEAD_BEEF);
        observe(16, -1);
        check("rd_ack_at", 32'(wb_ack_at), 32'd13);
        check("rd_ack_n",  32'(wb_ack_n), 32'd1);
        check("rd_en_we",  32'(en_we), 32'h0);

        // ties straight after reset alternate WB, ENG, WB, ENG
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst2_outs", 32'(outs_any), 32'd0);
        rst = 1'b0;
        start();
        wb_issue(1'b0, 32'h3800_0010, 4'hF, 32'h0, 32'hDEAD_BEEF);
        eng_issue(1'b0, 12'd4, 32'h0, 32'hDEAD_BEEF);
        observe(32, -1);
        check("tie_wb_ack_at",  32'(wb_ack_at), 32'd13);
        check("tie_eng_gnt_at", 32'(gnt_first), 32'd15);
        check("tie_eng_ack_at", 32'(eng_ack_at), 32'd27);
        check("tie_eng_ack_n",  32'(eng_ack_n), 32'd1);

        start();
        wb_issue(1'b1, 32'h3800_0024, 4'h3, 32'hAAAA_5555, 32'h0);
        eng_issue(1'b0, 12'd4, 32'h0, 32'hDEAD_BEEF);
        observe(32, -1);
        check("tie3_wb_ack_at",  32'(wb_ack_at), 32'd13);
        check("tie3_eng_ack_at", 32'(eng_ack_at), 32'd27);
        check("tie3_mem9",       mem[9], 32'h0000_5555);

        // engine write to word 7
        start();
        eng_issue(1'b1, 12'd7, 32'h1234_5678, 32'h0);
        observe(16, -1);
        check("ew_en_we",     32'(en_we), 32'hF);
        check("ew_en_adr",    32'(en_adr), 32'd7);
        check("ew_gnt_n",     32'(gnt_n), 32'd13);
        check("ew_ack_n",     32'(eng_ack_n), 32'd1);
        check("ew_ack_at",    32'(eng_ack_at), 32'd13);
        check("ew_wb_ack_n",  32'(wb_ack_n), 32'd0);
        check("ew_mem7",      mem[7], 32'h1234_5678);

        // WB abort in WAIT with an engine read pending
        start();
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3800_0010; wbs_sel_i = 4'hF;
        eng_issue(1'b0, 12'd7, 32'h0, 32'h1234_5678);
        observe(24, 5);
        check("ab_wb_ack_n",  32'(wb_ack_n), 32'd0);
        check("ab_en_n",      32'(en_n), 32'd1);
        check("ab_en_at",     32'(en_at), 32'd17);
        check("ab_eng_gnt",   32'(gnt_first), 32'd7);
        check("ab_eng_ack",   32'(eng_ack_at), 32'd19);

        // reset during WAIT of an engine write
        start();
        eng_req_i = 1'b1; eng_we_i = 1'b1; eng_adr_i = 12'd2; eng_dat_i = 32'h55AA_55AA;
        repeat (3) @(posedge clk);
        #1;
        check("mid_gnt", 32'(eng_gnt_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", 32'(outs_any), 32'd0);
        eng_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = cyc_n;
        observe(14, -1);
        check("mid_en_n",  32'(en_n), 32'd0);
        check("mid_ack_n", 32'(eng_ack_n), 32'd0);
        check("mid_mem2",  mem[2], 32'h0);

        // DELAYS=0 instance
        z_run(1'b1, 12'd3, 32'hCAFE_F00D, z_en_at, z_ack_at, z_gnt_n, z_rd);
        check("z_wr_en_at",  32'(z_en_at), 32'd1);
        check("z_wr_ack_at", 32'(z_ack_at), 32'd3);
        check("z_wr_gnt_n",  32'(z_gnt_n), 32'd3);
        check("z_mem3",      z_mem[3], 32'hCAFE_F00D);
        z_run(1'b0, 12'd3, 32'h0, z_en_at, z_ack_at, z_gnt_n, z_rd);
        check("z_rd_ack_at", 32'(z_ack_at), 32'd3);
        check("z_rd_data",   z_rd, 32'hCAFE_F00D);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
